// File: rtl/counter_seq_pkg.sv
// Shared state and command encodings for the counter sequencer and its bench.
package counter_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RUN_UP   = 3'd2,
        RUN_DOWN = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [1:0] MODE_UP_ONCE   = 2'b00;
    localparam logic [1:0] MODE_DOWN_ONCE = 2'b01;
    localparam logic [1:0] MODE_BOUNCE    = 2'b10;
    localparam logic [1:0] MODE_FREE      = 2'b11;

endpackage

// File: rtl/updown_counter_core.sv
// Loadable up/down counter datapath; load beats enable, arithmetic wraps.
module updown_counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_down,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = up_down ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer: steps the counter core through up, down, bounce
// and free-running runs, reporting busy/done/aborted status.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  limit,
    input  logic [PASS_W-1:0] passes,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              up_down,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [PASS_W-1:0] pass_cnt,
    output logic [2:0]        dbg_state
);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [WIDTH-1:0]  limit_q, limit_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic              aborted_q, aborted_d;
    logic              up_down_q, up_down_d;

    logic              core_en;
    logic              core_load;
    logic [WIDTH-1:0]  core_load_val;
    logic [PASS_W-1:0] eff_passes;

    assign eff_passes = (passes_q == '0) ? PASS_W'(1) : passes_q;

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        limit_d       = limit_q;
        passes_d      = passes_q;
        pass_cnt_d    = pass_cnt_q;
        aborted_d     = aborted_q;
        core_en       = 1'b0;
        core_load     = 1'b0;
        core_load_val = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    limit_d    = limit;
                    passes_d   = passes;
                    pass_cnt_d = '0;
                    aborted_d  = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (mode_q == MODE_DOWN_ONCE) begin
                    core_load     = 1'b1;
                    core_load_val = limit_q;
                    state_d       = RUN_DOWN;
                end else begin
                    core_load = 1'b1;
                    state_d   = RUN_UP;
                end
            end
            RUN_UP: begin
                // Reaching the limit costs a dwell cycle with no step.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (mode_q == MODE_FREE || count != limit_q) begin
                    core_en = 1'b1;
                end else if (mode_q == MODE_BOUNCE) begin
                    state_d = RUN_DOWN;
                end else begin
                    state_d = DONE;
                end
            end
            RUN_DOWN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (count != '0) begin
                    core_en = 1'b1;
                end else if (mode_q == MODE_BOUNCE) begin
                    pass_cnt_d = pass_cnt_q + PASS_W'(1);
                    state_d    = (pass_cnt_d == eff_passes) ? DONE : RUN_UP;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Direction follows the state being entered so it is valid on arrival.
        up_down_d = up_down_q;
        if (state_d == RUN_UP) begin
            up_down_d = 1'b1;
        end else if (state_d == RUN_DOWN) begin
            up_down_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mode_q     <= MODE_UP_ONCE;
            limit_q    <= '0;
            passes_q   <= '0;
            pass_cnt_q <= '0;
            aborted_q  <= 1'b0;
            up_down_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            limit_q    <= limit_d;
            passes_q   <= passes_d;
            pass_cnt_q <= pass_cnt_d;
            aborted_q  <= aborted_d;
            up_down_q  <= up_down_d;
        end
    end

    updown_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .en       (core_en),
        .load     (core_load),
        .load_val (core_load_val),
        .up_down  (up_down_q),
        .count    (count)
    );

    assign up_down   = up_down_q;
    assign busy      = (state_q == LOAD) || (state_q == RUN_UP) || (state_q == RUN_DOWN);
    assign done      = (state_q == DONE);
    assign aborted   = aborted_q;
    assign pass_cnt  = pass_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: per-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [3:0] limit;
    logic [3:0] passes;
    logic       abort;
    logic [3:0] count;
    logic       up_down;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] pass_cnt;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    counter_sequencer #(.WIDTH(4), .PASS_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .limit     (limit),
        .passes    (passes),
        .abort     (abort),
        .count     (count),
        .up_down   (up_down),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .pass_cnt  (pass_cnt),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [1:0] mode;
        logic [3:0] limit;
        logic [3:0] passes;
        logic       abort;
        logic [3:0] e_count;
        logic       e_ud;
        logic       e_busy;
        logic       e_done;
        logic       e_ab;
        logic [3:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic [1:0] m, input logic [3:0] l,
                       input logic [3:0] p, input logic a, input logic [3:0] c,
                       input logic ud, input logic b, input logic d,
                       input logic ab, input logic [3:0] pc);
        vec_t v;
        v.start = s; v.mode = m; v.limit = l; v.passes = p; v.abort = a;
        v.e_count = c; v.e_ud = ud; v.e_busy = b; v.e_done = d; v.e_ab = ab; v.e_pc = pc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [1:0] m, input logic [3:0] l,
                         input logic [3:0] p, input logic a);
        start = s; mode = m; limit = l; passes = p; abort = a;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] c, input logic ud,
                           input logic b, input logic d, input logic ab, input logic [3:0] pc);
        chk({tag, " count"}, 32'(count), 32'(c));
        chk({tag, " up_down"}, 32'(up_down), 32'(ud));
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " done"}, 32'(done), 32'(d));
        chk({tag, " aborted"}, 32'(aborted), 32'(ab));
        chk({tag, " pass_cnt"}, 32'(pass_cnt), 32'(pc));
    endtask

    initial begin
        int done_edge;
        int cnt_at_done;
        int ud_at_done;
        int k3_count;
        int saw_done;

        reset = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);

        // ---------------- reset state ----------------
        step();
        chk_all("reset", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("reset state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        step();
        chk_all("post reset idle", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // ---------------- vector table ----------------
        // UP_ONCE limit 5: LOAD, 0..5, dwell->DONE, IDLE holding 5
        add(1, MODE_UP_ONCE, 5, 0, 0,  0, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         1, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         2, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         3, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         4, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         5, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         5, 1, 0, 1, 0, 0);
        add(0, 2'b00, 0, 0, 0,         5, 1, 0, 0, 0, 0);
        add(0, 2'b00, 9, 0, 0,         5, 1, 0, 0, 0, 0);
        // DOWN_ONCE limit 3
        add(1, MODE_DOWN_ONCE, 3, 0, 0, 5, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         3, 0, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         2, 0, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         1, 0, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 0, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 0, 0, 1, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 0, 0, 0, 0, 0);
        // UP_ONCE limit 0: one RUN_UP cycle then DONE
        add(1, MODE_UP_ONCE, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 1, 0, 1, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 1, 0, 0, 0, 0);
        // abort alone in IDLE is ignored
        add(0, 2'b00, 0, 0, 1,         0, 1, 0, 0, 0, 0);
        // BOUNCE limit 2 passes 2
        add(1, MODE_BOUNCE, 2, 2, 0,   0, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         1, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         2, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         2, 0, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         1, 0, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 0, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 1, 1, 0, 0, 1);
        add(0, 2'b00, 0, 0, 0,         1, 1, 1, 0, 0, 1);
        add(0, 2'b00, 0, 0, 0,         2, 1, 1, 0, 0, 1);
        add(0, 2'b00, 0, 0, 0,         2, 0, 1, 0, 0, 1);
        add(0, 2'b00, 0, 0, 0,         1, 0, 1, 0, 0, 1);
        add(0, 2'b00, 0, 0, 0,         0, 0, 1, 0, 0, 1);
        add(0, 2'b00, 0, 0, 0,         0, 0, 0, 1, 0, 2);
        add(0, 2'b00, 0, 0, 0,         0, 0, 0, 0, 0, 2);
        // BOUNCE limit 1 passes 0 behaves as a single pass
        add(1, MODE_BOUNCE, 1, 0, 0,   0, 0, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         1, 1, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         1, 0, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 0, 1, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0,         0, 0, 0, 1, 0, 1);
        add(0, 2'b00, 0, 0, 0,         0, 0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].mode, vecs[i].limit, vecs[i].passes, vecs[i].abort);
            step();
            chk_all($sformatf("v%0d", i), vecs[i].e_count, vecs[i].e_ud, vecs[i].e_busy,
                    vecs[i].e_done, vecs[i].e_ab, vecs[i].e_pc);
        end
        drive(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);

        // ---------------- start while busy is ignored ----------------
        drive(1'b1, MODE_UP_ONCE, 4'd7, 4'd0, 1'b0);
        step();
        done_edge = 0; cnt_at_done = 0; ud_at_done = 0; k3_count = -1;
        for (int k = 1; k <= 12; k++) begin
            drive((k <= 4), MODE_DOWN_ONCE, 4'd2, 4'd3, 1'b0);
            step();
            if (k == 3) k3_count = int'(count);
            if (done && done_edge == 0) begin
                done_edge = k; cnt_at_done = int'(count); ud_at_done = int'(up_down);
            end
        end
        drive(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);
        chk("busy-start count k3", 32'(k3_count), 32'd2);
        chk("busy-start done edge", 32'(done_edge), 32'd9);
        chk("busy-start final count", 32'(cnt_at_done), 32'd7);
        chk("busy-start up_down", 32'(ud_at_done), 32'd1);
        chk("busy-start back idle", 32'(busy), 32'd0);

        // ---------------- FREE_RUN wrap then abort ----------------
        drive(1'b1, MODE_FREE, 4'd5, 4'd0, 1'b0);
        step();
        drive(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("free k%0d count", k), 32'(count), 32'((k - 1) % 16));
            chk($sformatf("free k%0d busy", k), 32'(busy), 32'd1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("free abort", 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        step();
        chk_all("free after abort", 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        step();
        chk("aborted sticky", 32'(aborted), 32'd1);

        // ---------------- abort and start together in IDLE ----------------
        drive(1'b1, MODE_UP_ONCE, 4'd1, 4'd0, 1'b1);
        step();
        drive(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);
        chk_all("abort+start load", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        step();
        chk_all("abort+start run0", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        step();
        chk_all("abort+start run1", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        step();
        chk_all("abort+start done", 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        step();

        // ---------------- abort during LOAD ----------------
        drive(1'b1, MODE_DOWN_ONCE, 4'd9, 4'd0, 1'b0);
        step();
        drive(1'b0, 2'b00, 4'd0, 4'd0, 1'b1);
        step();
        abort = 1'b0;
        chk_all("load abort", 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        step();

        // ---------------- async reset mid-BOUNCE ----------------
        drive(1'b1, MODE_BOUNCE, 4'd1, 4'd3, 1'b0);
        step();
        drive(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 7; k++) step();
        chk_all("pre-reset bounce", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async reset", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("async reset state", 32'(dbg_state), 32'(IDLE));
        saw_done = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (done) saw_done = 1;
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (done) saw_done = 1;
        end
        chk("no done after reset", 32'(saw_done), 32'd0);
        chk_all("idle after reset", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
